// File: rtl/clause_chunk_evaluator_pkg.sv
// Shared constants and types for the clause evaluation path.
// Holds the counter index width, the default array geometry shared with
// ta_state_counter, and the beat record carried through the pipeline.
package clause_chunk_evaluator_pkg;

   localparam int unsigned CNT_W_DEF      = 17;
   localparam int unsigned CLAUSES_DEF    = 10;
   localparam int unsigned LA_CHUNKS_DEF  = 10;
   localparam int unsigned CHUNK_BITS_DEF = 32;

   // One counter beat: qualification flag plus the addressed clause/chunk.
   typedef struct packed {
      logic                 valid;
      logic [CNT_W_DEF-1:0] clause_idx;
      logic [CNT_W_DEF-1:0] chunk_idx;
   } beat_t;

endpackage

// File: rtl/clause_chunk_evaluator_reduce.sv
// clause_chunk_reduce: combinational reduction of one TA/literal chunk.
// Ports:
//   ta_action_i  - TA include bits of the chunk
//   literal_i    - literal bits of the chunk
//   fail_c_o     - some included literal is 0
//   nonempty_c_o - at least one literal is included
module clause_chunk_reduce
   import clause_chunk_evaluator_pkg::*;
#(
   parameter int unsigned CHUNK_BITS = CHUNK_BITS_DEF
) (
   input  logic [CHUNK_BITS-1:0] ta_action_i,
   input  logic [CHUNK_BITS-1:0] literal_i,
   output logic                  fail_c_o,
   output logic                  nonempty_c_o
);

   assign fail_c_o     = |(ta_action_i & ~literal_i);
   assign nonempty_c_o = |ta_action_i;

endmodule

// File: rtl/clause_chunk_evaluator.sv
// clause_chunk_evaluator: evaluates clauses chunk by chunk from the TA
// state counter beats and the TA memory read data one cycle later.
// Ports:
//   clk, rst_flag_n          - clock, async active-low reset
//   stop_flag                - no counter beat this cycle
//   clause_count/la_chunk_count - counter indices of this cycle
//   ta_action_chunk/literal_chunk - chunk data, one cycle after its beat
//   predict_mode             - 1: empty clause -> 0, 0: empty clause -> 1
//   out_ready                - downstream accepts clause result
//   clause_out_valid/clause_out/clause_out_index - held clause result
//   clause_vector/vector_valid - assembled clause vector and its pulse
//   stall_flag               - result held but not accepted (combinational)
module clause_chunk_evaluator
   import clause_chunk_evaluator_pkg::*;
#(
   parameter int unsigned CLAUSES    = CLAUSES_DEF,
   parameter int unsigned LA_CHUNKS  = LA_CHUNKS_DEF,
   parameter int unsigned CHUNK_BITS = CHUNK_BITS_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_flag_n,
   input  logic                  stop_flag,
   input  logic [CNT_W-1:0]      clause_count,
   input  logic [CNT_W-1:0]      la_chunk_count,
   input  logic [CHUNK_BITS-1:0] ta_action_chunk,
   input  logic [CHUNK_BITS-1:0] literal_chunk,
   input  logic                  predict_mode,
   input  logic                  out_ready,
   output logic                  clause_out_valid,
   output logic                  clause_out,
   output logic [CNT_W-1:0]      clause_out_index,
   output logic [CLAUSES-1:0]    clause_vector,
   output logic                  vector_valid,
   output logic                  stall_flag
);

   // A held result stops the counter one beat late; that beat must never
   // be a final chunk, so at least two chunks per clause are needed.
   if (LA_CHUNKS < 2) begin : g_la_chunks_check
      $error("clause_chunk_evaluator: LA_CHUNKS must be >= 2");
   end
   if (CNT_W != CNT_W_DEF) begin : g_cnt_w_check
      $error("clause_chunk_evaluator: CNT_W must match the shared counter width");
   end

   beat_t               beat_q, beat_d;
   logic                acc_fail_q, acc_fail_d;
   logic                acc_ne_q, acc_ne_d;
   logic                out_valid_q, out_valid_d;
   logic                out_q, out_d;
   logic [CNT_W-1:0]    out_idx_q, out_idx_d;
   logic [CLAUSES-1:0]  vector_q, vector_d;
   logic                vec_valid_q, vec_valid_d;

   logic fail_chunk, ne_chunk;
   logic first_chunk, last_chunk;
   logic fail_total, ne_total, result, complete;

   clause_chunk_reduce #(
      .CHUNK_BITS (CHUNK_BITS)
   ) u_reduce (
      .ta_action_i  (ta_action_chunk),
      .literal_i    (literal_chunk),
      .fail_c_o     (fail_chunk),
      .nonempty_c_o (ne_chunk)
   );

   // Chunk 0 starts a fresh clause, so the stale accumulator is masked out.
   assign first_chunk = (beat_q.chunk_idx == '0);
   assign last_chunk  = (beat_q.chunk_idx == CNT_W_DEF'(LA_CHUNKS - 1));
   assign fail_total  = fail_chunk | (acc_fail_q & ~first_chunk);
   assign ne_total    = ne_chunk   | (acc_ne_q   & ~first_chunk);
   assign result      = ~fail_total & (ne_total | ~predict_mode);
   assign complete    = beat_q.valid & last_chunk;

   // Next-state logic for beat pipeline, accumulators and result outputs.
   always_comb begin
      beat_d.valid      = ~stop_flag & (clause_count < CNT_W'(CLAUSES));
      beat_d.clause_idx = clause_count;
      beat_d.chunk_idx  = la_chunk_count;
      acc_fail_d        = acc_fail_q;
      acc_ne_d          = acc_ne_q;
      out_valid_d       = out_valid_q;
      out_d             = out_q;
      out_idx_d         = out_idx_q;
      vector_d          = vector_q;
      vec_valid_d       = 1'b0;

      if (beat_q.valid) begin
         acc_fail_d = fail_total;
         acc_ne_d   = ne_total;
      end

      // A completing clause takes priority over the handshake clearing valid.
      if (complete) begin
         out_valid_d = 1'b1;
         out_d       = result;
         out_idx_d   = beat_q.clause_idx;
         for (int unsigned i = 0; i < CLAUSES; i++) begin
            if (beat_q.clause_idx == CNT_W_DEF'(i)) begin
               vector_d[i] = result;
            end
         end
         vec_valid_d = (beat_q.clause_idx == CNT_W_DEF'(CLAUSES - 1));
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_flag_n) begin
      if (!rst_flag_n) begin
         beat_q      <= '0;
         acc_fail_q  <= 1'b0;
         acc_ne_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= 1'b0;
         out_idx_q   <= '0;
         vector_q    <= '0;
         vec_valid_q <= 1'b0;
      end else begin
         beat_q      <= beat_d;
         acc_fail_q  <= acc_fail_d;
         acc_ne_q    <= acc_ne_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         out_idx_q   <= out_idx_d;
         vector_q    <= vector_d;
         vec_valid_q <= vec_valid_d;
      end
   end

   assign clause_out_valid = out_valid_q;
   assign clause_out       = out_q;
   assign clause_out_index = out_idx_q;
   assign clause_vector    = vector_q;
   assign vector_valid     = vec_valid_q;
   assign stall_flag       = out_valid_q & ~out_ready;

endmodule
